// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 multiplier with valid/ready handshake, sideband tag and flush.
// Flush-to-zero on denormal inputs, round-to-nearest-even, no denormal outputs.
module fmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x1,
  input  logic [EXP_W+MAN_W:0]   x2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   y,
  output logic                   ovf,
  output logic                   udf,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  if (STAGES < 1 || STAGES > 3) begin : gBadStages
    $error("fmul_pipe: STAGES must be in 1..3");
  end

  typedef struct packed {
    logic                  sign;
    logic [1:0]            sp;
    logic signed [EW2-1:0] exp;
    logic [PW-1:0]         prod;
  } stageA_t;

  typedef struct packed {
    logic                  sign;
    logic [1:0]            sp;
    logic signed [EW2-1:0] exp;
    logic [MAN_W:0]        mant;
    logic                  guard;
    logic                  sticky;
  } stageB_t;

  logic            advance;
  logic            outValid_q;
  logic [W-1:0]    y_q;
  logic            ovf_q;
  logic            udf_q;
  logic [TAG_W-1:0] tag_q;

  stageA_t          aStage_d;
  stageA_t          bIn;
  logic             bInValid;
  logic [TAG_W-1:0] bInTag;
  stageB_t          bStage_d;
  stageB_t          cIn;
  logic             cInValid;
  logic [TAG_W-1:0] cInTag;
  logic [W-1:0]     y_d;
  logic             ovf_d;
  logic             udf_d;

  assign advance  = !outValid_q || out_ready;
  assign in_ready = advance;

  always_comb begin
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    logic nan1, nan2, inf1, inf2, zero1, zero2;
    e1 = x1[W-2:MAN_W];
    e2 = x2[W-2:MAN_W];
    m1 = x1[MAN_W-1:0];
    m2 = x2[MAN_W-1:0];
    nan1  = (&e1) && (|m1);
    nan2  = (&e2) && (|m2);
    inf1  = (&e1) && !(|m1);
    inf2  = (&e2) && !(|m2);
    zero1 = (e1 == '0);
    zero2 = (e2 == '0);
    aStage_d.sign = x1[W-1] ^ x2[W-1];
    // inf*0 is invalid, so it must win over both the inf and zero cases
    if (nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1)) aStage_d.sp = SP_NAN;
    else if (inf1 || inf2)                                  aStage_d.sp = SP_INF;
    else if (zero1 || zero2)                                aStage_d.sp = SP_ZERO;
    else                                                    aStage_d.sp = SP_NONE;
    aStage_d.exp  = $signed({2'b00, e1}) + $signed({2'b00, e2}) - $signed(EW2'(BIAS));
    aStage_d.prod = PW'({1'b1, m1}) * PW'({1'b1, m2});
  end

  if (STAGES == 3) begin : gRegA
    stageA_t          aStage_q;
    logic             aValid_q;
    logic [TAG_W-1:0] aTag_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        aStage_q <= '0;
        aValid_q <= 1'b0;
        aTag_q   <= '0;
      end else if (flush) begin
        aValid_q <= 1'b0;
      end else if (advance) begin
        aStage_q <= aStage_d;
        aValid_q <= in_valid;
        aTag_q   <= in_tag;
      end
    end
    assign bIn      = aStage_q;
    assign bInValid = aValid_q;
    assign bInTag   = aTag_q;
  end else begin : gNoRegA
    assign bIn      = aStage_d;
    assign bInValid = in_valid;
    assign bInTag   = in_tag;
  end

  always_comb begin
    bStage_d.sign = bIn.sign;
    bStage_d.sp   = bIn.sp;
    if (bIn.prod[PW-1]) begin
      bStage_d.exp    = bIn.exp + EW2'(1);
      bStage_d.mant   = bIn.prod[PW-1:MAN_W+1];
      bStage_d.guard  = bIn.prod[MAN_W];
      bStage_d.sticky = |bIn.prod[MAN_W-1:0];
    end else begin
      bStage_d.exp    = bIn.exp;
      bStage_d.mant   = bIn.prod[PW-2:MAN_W];
      bStage_d.guard  = bIn.prod[MAN_W-1];
      bStage_d.sticky = |bIn.prod[MAN_W-2:0];
    end
  end

  if (STAGES >= 2) begin : gRegB
    stageB_t          bStage_q;
    logic             bValid_q;
    logic [TAG_W-1:0] bTag_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        bStage_q <= '0;
        bValid_q <= 1'b0;
        bTag_q   <= '0;
      end else if (flush) begin
        bValid_q <= 1'b0;
      end else if (advance) begin
        bStage_q <= bStage_d;
        bValid_q <= bInValid;
        bTag_q   <= bInTag;
      end
    end
    assign cIn      = bStage_q;
    assign cInValid = bValid_q;
    assign cInTag   = bTag_q;
  end else begin : gNoRegB
    assign cIn      = bStage_d;
    assign cInValid = bInValid;
    assign cInTag   = bInTag;
  end

  always_comb begin
    logic                  roundUp;
    logic [MAN_W+1:0]      mantR;
    logic signed [EW2-1:0] expR;
    logic [MAN_W-1:0]      frac;
    roundUp = cIn.guard & (cIn.sticky | cIn.mant[0]);
    mantR   = {1'b0, cIn.mant} + (MAN_W+2)'(roundUp);
    // a rounding carry leaves 10.00..0, so the shifted fraction is all zeros
    expR    = cIn.exp + $signed({{(EW2-1){1'b0}}, mantR[MAN_W+1]});
    frac    = mantR[MAN_W+1] ? mantR[MAN_W:1] : mantR[MAN_W-1:0];
    ovf_d   = 1'b0;
    udf_d   = 1'b0;
    y_d     = {cIn.sign, expR[EXP_W-1:0], frac};
    case (cIn.sp)
      SP_NAN:  y_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      SP_INF:  y_d = {cIn.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: y_d = {cIn.sign, {(W-1){1'b0}}};
      default: begin
        if (expR >= $signed(EW2'(EMAX))) begin
          y_d   = {cIn.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d = 1'b1;
        end else if (expR <= 0) begin
          y_d   = {cIn.sign, {(W-1){1'b0}}};
          udf_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outValid_q <= 1'b0;
      y_q        <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      tag_q      <= '0;
    end else if (flush) begin
      outValid_q <= 1'b0;
    end else if (advance) begin
      outValid_q <= cInValid;
      y_q        <= y_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      tag_q      <= cInTag;
    end
  end

  assign out_valid = outValid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Bench for fmul_pipe: drives STAGES=1,2,3 instances from shared inputs and
// checks every cycle against an arithmetic reference and a frozen-pipe model.
module tb_fmul_pipe;

  localparam int W     = 32;
  localparam int TAG_W = 5;

  typedef struct {
    bit               v;
    logic [W-1:0]     y;
    bit               ovf;
    bit               udf;
    logic [TAG_W-1:0] tag;
  } slot_t;

  logic clk = 1'b0;
  logic rstn, flush, inValid, outReady;
  logic [W-1:0]     x1, x2;
  logic [TAG_W-1:0] inTag;

  logic             inReadyV  [1:3];
  logic             outValidV [1:3];
  logic [W-1:0]     yV        [1:3];
  logic             ovfV      [1:3];
  logic             udfV      [1:3];
  logic [TAG_W-1:0] tagV      [1:3];

  slot_t pipeM [1:3][0:2];
  logic [TAG_W-1:0] consumedTags [$];
  int  testsRun  = 0;
  int  failCount = 0;
  bit  checking  = 0;
  int  lat [1:3];

  always #5 clk = ~clk;

  for (genvar d = 1; d <= 3; d++) begin : gDut
    fmul_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(d), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(inValid), .in_ready(inReadyV[d]),
      .x1(x1), .x2(x2), .in_tag(inTag),
      .out_valid(outValidV[d]), .out_ready(outReady),
      .y(yV[d]), .ovf(ovfV[d]), .udf(udfV[d]), .out_tag(tagV[d])
    );
  end

  // Reference product from plain integer arithmetic: {ovf, udf, y}
  function automatic logic [33:0] refMul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint ma, mb, p, mant, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
      return {2'b00, 32'h7FC00000};
    if (ea == 255 || eb == 255) return {2'b00, s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0)     return {2'b00, s, 31'h0};
    p = ((longint'(1) << 23) + ma) * ((longint'(1) << 23) + mb);
    e = ea + eb - 127;
    if (p >= (longint'(1) << 47)) begin
      e++;
      sh = 24;
    end else begin
      sh = 23;
    end
    mant = p >> sh;
    rem  = p - (mant << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
    if (mant == (longint'(1) << 24)) begin
      mant = mant >> 1;
      e++;
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'h0};
    if (e <= 0)   return {2'b01, s, 31'h0};
    return {2'b00, s, 8'(e), 23'(mant)};
  endfunction

  function automatic logic [31:0] randOp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return r;
      1: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
      2: return {r[31], ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 40))
                                                    : 8'($urandom_range(200, 254)), r[22:0]};
      3: case (r[1:0])
           2'd0: return {r[31], 31'h0};
           2'd1: return {r[31], 8'hFF, 23'h0};
           2'd2: return {r[31], 8'hFF, r[22:1], 1'b1};
           default: return {r[31], 8'h00, r[22:0]};
         endcase
      default: return {r[31], 8'($urandom_range(110, 144)), 23'h7FFFFF - 23'(r[3:0])};
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] t);
    @(posedge clk);
    #1;
    inValid = v;
    x1      = a;
    x2      = b;
    inTag   = t;
  endtask

  task automatic checkResetZero(input string name);
    for (int d = 1; d <= 3; d++) begin
      checkVal($sformatf("%s_s%0d_valid", name, d), 64'(outValidV[d]), 64'd0);
      checkVal($sformatf("%s_s%0d_y", name, d), 64'(yV[d]), 64'd0);
      checkVal($sformatf("%s_s%0d_flags", name, d), 64'({ovfV[d], udfV[d]}), 64'd0);
      checkVal($sformatf("%s_s%0d_tag", name, d), 64'(tagV[d]), 64'd0);
    end
  endtask

  task automatic checkOutput();
    slot_t s;
    bit    expValid;
    for (int d = 1; d <= 3; d++) begin
      s        = pipeM[d][d-1];
      expValid = rstn && s.v;
      checkVal($sformatf("s%0d_out_valid", d), 64'(outValidV[d]), 64'(expValid));
      checkVal($sformatf("s%0d_in_ready", d), 64'(inReadyV[d]), 64'(!expValid || outReady));
      if (!rstn) begin
        checkVal($sformatf("s%0d_rst_y", d), 64'(yV[d]), 64'd0);
        checkVal($sformatf("s%0d_rst_tag", d), 64'({tagV[d], ovfV[d], udfV[d]}), 64'd0);
      end else if (expValid) begin
        checkVal($sformatf("s%0d_y", d), 64'(yV[d]), 64'(s.y));
        checkVal($sformatf("s%0d_ovf_udf", d), 64'({ovfV[d], udfV[d]}), 64'({s.ovf, s.udf}));
        checkVal($sformatf("s%0d_tag", d), 64'(tagV[d]), 64'(s.tag));
      end
    end
  endtask

  // Each instance is modelled as STAGES slots that shift together or freeze whole
  always @(posedge clk) begin
    logic [33:0] r;
    bit adv;
    r = refMul(x1, x2);
    for (int d = 1; d <= 3; d++) begin
      if (!rstn || flush) begin
        for (int k = 0; k < 3; k++) pipeM[d][k].v = 1'b0;
      end else begin
        adv = !pipeM[d][d-1].v || outReady;
        if (adv) begin
          for (int k = d - 1; k > 0; k--) pipeM[d][k] = pipeM[d][k-1];
          pipeM[d][0].v   = inValid;
          pipeM[d][0].y   = r[31:0];
          pipeM[d][0].ovf = r[33];
          pipeM[d][0].udf = r[32];
          pipeM[d][0].tag = inTag;
        end
      end
    end
  end

  always @(negedge rstn) begin
    for (int d = 1; d <= 3; d++)
      for (int k = 0; k < 3; k++) pipeM[d][k].v = 1'b0;
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput();
      if (rstn && outValidV[2] && outReady) consumedTags.push_back(tagV[2]);
    end
  end

  task automatic resetPulse();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checkResetZero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    x1 = '0; x2 = '0; inTag = '0;
    for (int d = 1; d <= 3; d++) lat[d] = 0;
    #3;
    rstn = 1'b0;
    checking = 1;
    #1;
    checkResetZero("por");
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    checkVal("ref_1p5x2", 64'(refMul(32'h3FC00000, 32'h40000000)), 64'({2'b00, 32'h40400000}));
    checkVal("ref_rne", 64'(refMul(32'h3F800001, 32'h3F800001)), 64'({2'b00, 32'h3F800002}));
    checkVal("ref_ovf", 64'(refMul(32'h7F000000, 32'h7F000000)), 64'({2'b10, 32'h7F800000}));
    checkVal("ref_udf", 64'(refMul(32'h00800000, 32'h3F000000)), 64'({2'b01, 32'h00000000}));
    checkVal("ref_denorm", 64'(refMul(32'h80400000, 32'h3F800000)), 64'({2'b00, 32'h80000000}));
    checkVal("ref_inf0", 64'(refMul(32'h7F800000, 32'h00000000)), 64'({2'b00, 32'h7FC00000}));
    checkVal("ref_ninf", 64'(refMul(32'hFF800000, 32'h40000000)), 64'({2'b00, 32'hFF800000}));

    applyStimulus(1'b1, 32'h3FC00000, 32'h40000000, 5'd3);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) inValid = 1'b0;
      @(negedge clk);
      #1;
      for (int d = 1; d <= 3; d++) begin
        if (outValidV[d] && lat[d] == 0) begin
          lat[d] = k;
          checkVal($sformatf("lat_s%0d_y", d), 64'(yV[d]), 64'h40400000);
          checkVal($sformatf("lat_s%0d_tag", d), 64'(tagV[d]), 64'd3);
        end
      end
    end
    for (int d = 1; d <= 3; d++) checkVal($sformatf("latency_s%0d", d), 64'(lat[d]), 64'(d));

    applyStimulus(1'b1, 32'h3F800001, 32'h3F800001, 5'd4);
    applyStimulus(1'b1, 32'h7F000000, 32'h7F000000, 5'd5);
    applyStimulus(1'b1, 32'h00800000, 32'h3F000000, 5'd6);
    applyStimulus(1'b1, 32'h80400000, 32'h3F800000, 5'd7);
    applyStimulus(1'b1, 32'h7F800000, 32'h00000000, 5'd8);
    applyStimulus(1'b1, 32'hFF800000, 32'h40000000, 5'd9);
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0);
    repeat (4) @(posedge clk);

    consumedTags.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          applyStimulus(1'b1, randOp(), randOp(), 5'(10 + i));
          for (int g = 0; g < 20; g++) begin
            @(negedge clk);
            if (inReadyV[2]) break;
            @(posedge clk);
          end
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 5'd0);
      end
      begin
        for (int k = 0; k < 12 && !outValidV[2]; k++) @(negedge clk);
        checkVal("stall_first_result_seen", 64'(outValidV[2]), 64'd1);
        @(posedge clk);
        #1;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    checkVal("stall_count", 64'(consumedTags.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      checkVal($sformatf("stall_order_%0d", i),
               64'((consumedTags.size() > i) ? consumedTags[i] : 5'h1F), 64'(10 + i));

    applyStimulus(1'b1, 32'h3FC00000, 32'h40000000, 5'd20);
    applyStimulus(1'b1, 32'h40000000, 32'h40400000, 5'd21);
    applyStimulus(1'b1, 32'h40400000, 32'h40400000, 5'd22);
    flush = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkVal("flush_s3_quiet", 64'(outValidV[3]), 64'd0);
    end

    for (int c = 0; c < 400; c++) begin
      if (c == 200) resetPulse();
      applyStimulus($urandom_range(0, 9) < 7, randOp(), randOp(), 5'($urandom));
      outReady = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 49) == 0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 5'd0);
    outReady = 1'b1;
    flush    = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
